// File: rtl/matrix_slot_manager.sv
// rtl/matrix_slot_manager.sv - slot table for stored matrices, alloc/lookup arbiter and zero-fill sequencer
// Table state, indexed by spec: cnt (stored matrices) and head (oldest slot index, mod SLOTS_PER_SPEC).
module matrix_slot_manager #(
  parameter int MAX_DIM        = 5,
  parameter int SLOTS_PER_SPEC = 2,
  parameter int SLOT_WORDS     = 32,
  parameter int CLR_WORDS      = 25,
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [2:0]        alloc_m,
  input  logic [2:0]        alloc_n,
  output logic              alloc_gnt,
  output logic              alloc_err,
  output logic [ADDR_W-1:0] alloc_base,
  input  logic              lookup_req,
  input  logic [2:0]        lookup_m,
  input  logic [2:0]        lookup_n,
  input  logic [1:0]        lookup_id,
  output logic              lookup_gnt,
  output logic              lookup_hit,
  output logic [ADDR_W-1:0] lookup_base,
  output logic [1:0]        lookup_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  localparam int SPEC_N = MAX_DIM * MAX_DIM;
  localparam int SPEC_W = $clog2(SPEC_N);
  localparam int CLR_W  = $clog2(CLR_WORDS);
  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);
  localparam logic [1:0] CNT_FULL = 2'(SLOTS_PER_SPEC);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_WORDS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [1:0]        cnt_tbl  [SPEC_N];
  logic              head_tbl [SPEC_N];

  logic [SPEC_W-1:0] pend_spec;
  logic              pend_full;
  logic [ADDR_W-1:0] pend_base;
  logic [CLR_W-1:0]  clr_idx;

  function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m != 3'd0) && (m <= DIM_MAX) && (n != 3'd0) && (n <= DIM_MAX);
  endfunction

  function automatic logic [SPEC_W-1:0] spec_of(input logic [2:0] m, input logic [2:0] n);
    return SPEC_W'((int'(m) - 1) * MAX_DIM + (int'(n) - 1));
  endfunction

  function automatic logic [ADDR_W-1:0] slot_base(input logic [SPEC_W-1:0] s, input logic k);
    return ADDR_W'((int'(s) * SLOTS_PER_SPEC + int'(k)) * SLOT_WORDS);
  endfunction

  // Allocation candidate: next free slot after the newest, or the oldest once the spec is full.
  logic              a_ok;
  logic [SPEC_W-1:0] a_spec;
  logic [1:0]        a_cnt;
  logic              a_head;
  logic              a_full;
  logic              a_k;
  logic [ADDR_W-1:0] a_base;

  always_comb begin
    a_ok   = dims_ok(alloc_m, alloc_n);
    a_spec = a_ok ? spec_of(alloc_m, alloc_n) : '0;
    a_cnt  = cnt_tbl[a_spec];
    a_head = head_tbl[a_spec];
    a_full = (a_cnt == CNT_FULL);
    a_k    = a_full ? a_head : (a_head ^ a_cnt[0]);
    a_base = slot_base(a_spec, a_k);
  end

  // Lookup result: id 1 is the slot at head, ids count upward from there.
  logic              l_ok;
  logic [SPEC_W-1:0] l_spec;
  logic [1:0]        l_cnt;
  logic [1:0]        l_idm1;
  logic              l_hit;
  logic              l_k;
  logic [ADDR_W-1:0] l_base;

  always_comb begin
    l_ok   = dims_ok(lookup_m, lookup_n);
    l_spec = l_ok ? spec_of(lookup_m, lookup_n) : '0;
    l_cnt  = l_ok ? cnt_tbl[l_spec] : 2'd0;
    l_idm1 = lookup_id - 2'd1;
    l_hit  = l_ok && (lookup_id != 2'd0) && (lookup_id <= l_cnt);
    l_k    = head_tbl[l_spec] ^ l_idm1[0];
    l_base = l_hit ? slot_base(l_spec, l_k) : '0;
  end

  assign busy      = (state != ST_IDLE);
  assign mem_wdata = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      alloc_gnt   <= 1'b0;
      alloc_err   <= 1'b0;
      alloc_base  <= '0;
      lookup_gnt  <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_base <= '0;
      lookup_cnt  <= 2'd0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      pend_spec   <= '0;
      pend_full   <= 1'b0;
      pend_base   <= '0;
      clr_idx     <= '0;
      for (int i = 0; i < SPEC_N; i++) begin
        cnt_tbl[i]  <= 2'd0;
        head_tbl[i] <= 1'b0;
      end
    end else begin
      alloc_gnt  <= 1'b0;
      lookup_gnt <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A grant cycle never services: a request still held then is the one just granted.
          if (!alloc_gnt && !lookup_gnt) begin
            if (alloc_req) begin
              if (a_ok) begin
                pend_spec <= a_spec;
                pend_full <= a_full;
                pend_base <= a_base;
                mem_we    <= 1'b1;
                mem_addr  <= a_base;
                clr_idx   <= '0;
                state     <= ST_CLEAR;
              end else begin
                alloc_gnt  <= 1'b1;
                alloc_err  <= 1'b1;
                alloc_base <= '0;
              end
            end else if (lookup_req) begin
              lookup_gnt  <= 1'b1;
              lookup_hit  <= l_hit;
              lookup_base <= l_base;
              lookup_cnt  <= l_cnt;
            end
          end
        end
        ST_CLEAR: begin
          if (clr_idx == CLR_LAST) begin
            mem_we     <= 1'b0;
            state      <= ST_IDLE;
            alloc_gnt  <= 1'b1;
            alloc_err  <= 1'b0;
            alloc_base <= pend_base;
            if (pend_full) head_tbl[pend_spec] <= ~head_tbl[pend_spec];
            else           cnt_tbl[pend_spec]  <= cnt_tbl[pend_spec] + 2'd1;
          end else begin
            clr_idx  <= clr_idx + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_slot_manager.sv
// tb/tb_matrix_slot_manager.sv - directed self-checking bench for matrix_slot_manager
module tb_matrix_slot_manager;

  logic        clk;
  logic        rst;
  logic        alloc_req;
  logic [2:0]  alloc_m;
  logic [2:0]  alloc_n;
  logic        alloc_gnt;
  logic        alloc_err;
  logic [10:0] alloc_base;
  logic        lookup_req;
  logic [2:0]  lookup_m;
  logic [2:0]  lookup_n;
  logic [1:0]  lookup_id;
  logic        lookup_gnt;
  logic        lookup_hit;
  logic [10:0] lookup_base;
  logic [1:0]  lookup_cnt;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;

  int checks;
  int failures;

  matrix_slot_manager dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .alloc_gnt(alloc_gnt), .alloc_err(alloc_err), .alloc_base(alloc_base),
    .lookup_req(lookup_req), .lookup_m(lookup_m), .lookup_n(lookup_n), .lookup_id(lookup_id),
    .lookup_gnt(lookup_gnt), .lookup_hit(lookup_hit), .lookup_base(lookup_base), .lookup_cnt(lookup_cnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_alloc(input logic [2:0] m, input logic [2:0] n, output int lat, output int we_cnt,
                           output logic [10:0] first_a, output logic [10:0] last_a, output int bad);
    lat = 0; we_cnt = 0; bad = 0; first_a = '0; last_a = '0;
    @(posedge clk); #1;
    alloc_m = m; alloc_n = n; alloc_req = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (mem_we) begin
        if (we_cnt == 0) first_a = mem_addr;
        else if (mem_addr != 11'(last_a + 11'd1)) bad++;
        if (mem_wdata != 8'd0) bad++;
        last_a = mem_addr;
        we_cnt++;
      end
    end while (!alloc_gnt && lat < 60);
    alloc_req = 1'b0;
  endtask

  task automatic run_lookup(input logic [2:0] m, input logic [2:0] n, input logic [1:0] id, output int lat);
    lat = 0;
    @(posedge clk); #1;
    lookup_m = m; lookup_n = n; lookup_id = id; lookup_req = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!lookup_gnt && lat < 60);
    lookup_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alloc_req = 1'b0; alloc_m = '0; alloc_n = '0;
    lookup_req = 1'b0; lookup_m = '0; lookup_n = '0; lookup_id = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({alloc_gnt, alloc_err, alloc_base, lookup_gnt, lookup_hit, lookup_base, lookup_cnt, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b err=%b abase=%0d lgnt=%b hit=%b lbase=%0d cnt=%0d we=%b addr=%0d busy=%b, want all 0",
               alloc_gnt, alloc_err, alloc_base, lookup_gnt, lookup_hit, lookup_base, lookup_cnt, mem_we, mem_addr, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_alloc_first();
    int lat, we_cnt, bad;
    logic [10:0] fa, la;
    run_alloc(3'd2, 3'd3, lat, we_cnt, fa, la, bad);
    checks++; if (lat !== 26) begin failures++; $display("FAIL alloc1_latency: got %0d want 26", lat); end
    checks++; if (we_cnt !== 25) begin failures++; $display("FAIL alloc1_we_count: got %0d want 25", we_cnt); end
    checks++; if (fa !== 11'd448 || la !== 11'd472 || bad !== 0) begin failures++; $display("FAIL alloc1_fill: got first=%0d last=%0d bad=%0d want 448 472 0", fa, la, bad); end
    checks++; if (alloc_base !== 11'd448 || alloc_err !== 1'b0) begin failures++; $display("FAIL alloc1_base: got base=%0d err=%b want 448 0", alloc_base, alloc_err); end
  endtask

  task automatic test_alloc_second();
    int lat, we_cnt, bad;
    logic [10:0] fa, la;
    run_alloc(3'd2, 3'd3, lat, we_cnt, fa, la, bad);
    checks++; if (lat !== 26 || alloc_base !== 11'd480 || fa !== 11'd480 || we_cnt !== 25) begin
      failures++; $display("FAIL alloc2: got lat=%0d base=%0d first=%0d we=%0d want 26 480 480 25", lat, alloc_base, fa, we_cnt); end
    run_lookup(3'd2, 3'd3, 2'd1, lat);
    checks++; if (lat !== 1 || lookup_hit !== 1'b1 || lookup_base !== 11'd448 || lookup_cnt !== 2'd2) begin
      failures++; $display("FAIL lookup_id1: got lat=%0d hit=%b base=%0d cnt=%0d want 1 1 448 2", lat, lookup_hit, lookup_base, lookup_cnt); end
    run_lookup(3'd2, 3'd3, 2'd2, lat);
    checks++; if (lookup_hit !== 1'b1 || lookup_base !== 11'd480 || lookup_cnt !== 2'd2) begin
      failures++; $display("FAIL lookup_id2: got hit=%b base=%0d cnt=%0d want 1 480 2", lookup_hit, lookup_base, lookup_cnt); end
  endtask

  task automatic test_replace();
    int lat, we_cnt, bad;
    logic [10:0] fa, la;
    run_alloc(3'd2, 3'd3, lat, we_cnt, fa, la, bad);
    checks++; if (alloc_base !== 11'd448 || fa !== 11'd448 || la !== 11'd472) begin
      failures++; $display("FAIL alloc3_replace: got base=%0d first=%0d last=%0d want 448 448 472", alloc_base, fa, la); end
    run_lookup(3'd2, 3'd3, 2'd1, lat);
    checks++; if (lookup_hit !== 1'b1 || lookup_base !== 11'd480 || lookup_cnt !== 2'd2) begin
      failures++; $display("FAIL replace_id1: got hit=%b base=%0d cnt=%0d want 1 480 2", lookup_hit, lookup_base, lookup_cnt); end
    run_lookup(3'd2, 3'd3, 2'd2, lat);
    checks++; if (lookup_hit !== 1'b1 || lookup_base !== 11'd448 || lookup_cnt !== 2'd2) begin
      failures++; $display("FAIL replace_id2: got hit=%b base=%0d cnt=%0d want 1 448 2", lookup_hit, lookup_base, lookup_cnt); end
  endtask

  task automatic test_arbitration();
    int a_lat, l_lat, early;
    a_lat = 0; l_lat = 0; early = 0;
    @(posedge clk); #1;
    alloc_m = 3'd2; alloc_n = 3'd2; alloc_req = 1'b1;
    lookup_m = 3'd2; lookup_n = 3'd3; lookup_id = 2'd1; lookup_req = 1'b1;
    do begin
      @(posedge clk); #1;
      a_lat++;
      if (lookup_gnt) early++;
    end while (!alloc_gnt && a_lat < 60);
    alloc_req = 1'b0;
    checks++; if (a_lat !== 26 || alloc_base !== 11'd384 || early !== 0) begin
      failures++; $display("FAIL arb_alloc_first: got lat=%0d base=%0d early_lookup=%0d want 26 384 0", a_lat, alloc_base, early); end
    do begin
      @(posedge clk); #1;
      l_lat++;
    end while (!lookup_gnt && l_lat < 60);
    lookup_req = 1'b0;
    checks++; if (l_lat !== 2 || lookup_hit !== 1'b1 || lookup_base !== 11'd480) begin
      failures++; $display("FAIL arb_lookup_after: got delay=%0d hit=%b base=%0d want 2 1 480", l_lat, lookup_hit, lookup_base); end
    run_lookup(3'd2, 3'd2, 2'd2, l_lat);
    checks++; if (lookup_hit !== 1'b0 || lookup_base !== 11'd0 || lookup_cnt !== 2'd1) begin
      failures++; $display("FAIL lookup_2x2_id2: got hit=%b base=%0d cnt=%0d want 0 0 1", lookup_hit, lookup_base, lookup_cnt); end
  endtask

  task automatic test_invalid_dims();
    int lat, we_cnt, bad;
    logic [10:0] fa, la;
    run_alloc(3'd0, 3'd3, lat, we_cnt, fa, la, bad);
    checks++; if (lat !== 1 || alloc_err !== 1'b1 || we_cnt !== 0) begin
      failures++; $display("FAIL alloc_0x3: got lat=%0d err=%b we=%0d want 1 1 0", lat, alloc_err, we_cnt); end
    run_alloc(3'd6, 3'd1, lat, we_cnt, fa, la, bad);
    checks++; if (lat !== 1 || alloc_err !== 1'b1 || we_cnt !== 0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL alloc_6x1: got lat=%0d err=%b we=%0d want 1 1 0", lat, alloc_err, we_cnt); end
    run_lookup(3'd1, 3'd3, 2'd1, lat);
    checks++; if (lookup_hit !== 1'b0 || lookup_cnt !== 2'd0 || lookup_base !== 11'd0) begin
      failures++; $display("FAIL lookup_1x3: got hit=%b cnt=%0d base=%0d want 0 0 0", lookup_hit, lookup_cnt, lookup_base); end
  endtask

  task automatic test_reset_mid_clear();
    int gnt_seen, lat;
    gnt_seen = 0;
    @(posedge clk); #1;
    alloc_m = 3'd5; alloc_n = 3'd5; alloc_req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (mem_we !== 1'b1 || busy !== 1'b1 || mem_addr !== 11'd1545) begin
      failures++; $display("FAIL clear_in_progress: got we=%b busy=%b addr=%0d want 1 1 1545", mem_we, busy, mem_addr); end
    rst = 1'b1; alloc_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || alloc_gnt !== 1'b0) begin
      failures++; $display("FAIL reset_abort: got we=%b busy=%b gnt=%b want 0 0 0", mem_we, busy, alloc_gnt); end
    repeat (30) begin
      @(posedge clk); #1;
      if (alloc_gnt || mem_we) gnt_seen++;
    end
    checks++; if (gnt_seen !== 0) begin failures++; $display("FAIL no_grant_after_abort: got %0d active cycles want 0", gnt_seen); end
    run_lookup(3'd5, 3'd5, 2'd1, lat);
    checks++; if (lookup_hit !== 1'b0 || lookup_cnt !== 2'd0) begin
      failures++; $display("FAIL lookup_5x5: got hit=%b cnt=%0d want 0 0", lookup_hit, lookup_cnt); end
    run_lookup(3'd2, 3'd3, 2'd1, lat);
    checks++; if (lookup_hit !== 1'b0 || lookup_cnt !== 2'd0) begin
      failures++; $display("FAIL table_cleared: got hit=%b cnt=%0d want 0 0", lookup_hit, lookup_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_alloc_first();
    test_alloc_second();
    test_replace();
    test_arbitration();
    test_invalid_dims();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
